// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared definitions for the sprite draw scheduler: sequencer states and
// the coordinate/colour widths used by the rectangle drawer interface.
package sprite_draw_scheduler_pkg;

    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int WH_W = 5;
    localparam int C_W  = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ERASE_SEL  = 3'd1,
        ERASE_WAIT = 3'd2,
        UPDATE     = 3'd3,
        SETTLE     = 3'd4,
        DRAW_SEL   = 3'd5,
        DRAW_WAIT  = 3'd6
    } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_frame_tick_gen.sv
// Free-running frame counter; tick is high for the last cycle of each frame.
module sprite_draw_scheduler_frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    // Count 0..FRAME_DIV-1 and wrap, regardless of what the sequencer is doing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (count_reg == LAST_COUNT) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign tick = (count_reg == LAST_COUNT);

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame sequencer sharing one rectangle drawer among all sprite slots:
// erase previously drawn sprites, pulse game update, then snapshot and draw.
module sprite_draw_scheduler
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int             NUM_SPR   = 5,
    parameter int             FRAME_DIV = 833333,
    parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [X_W*NUM_SPR-1:0]  spr_x,
    input  logic [Y_W*NUM_SPR-1:0]  spr_y,
    input  logic [WH_W*NUM_SPR-1:0] spr_w,
    input  logic [WH_W*NUM_SPR-1:0] spr_h,
    input  logic [C_W*NUM_SPR-1:0]  spr_c,
    input  logic [NUM_SPR-1:0]      spr_valid,
    output logic                    update_en,
    output logic                    rect_start,
    output logic [X_W-1:0]          rect_x,
    output logic [Y_W-1:0]          rect_y,
    output logic [WH_W-1:0]         rect_w,
    output logic [WH_W-1:0]         rect_h,
    output logic [C_W-1:0]          rect_c,
    input  logic                    rect_done,
    output logic                    busy,
    output logic                    overrun
);

    localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPR - 1);

    logic tick;

    sprite_draw_scheduler_frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

    // Unpacked views of the packed sprite buses
    logic [X_W-1:0]  in_x [NUM_SPR];
    logic [Y_W-1:0]  in_y [NUM_SPR];
    logic [WH_W-1:0] in_w [NUM_SPR];
    logic [WH_W-1:0] in_h [NUM_SPR];
    logic [C_W-1:0]  in_c [NUM_SPR];

    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_unpack
        assign in_x[gi] = spr_x[gi*X_W  +: X_W];
        assign in_y[gi] = spr_y[gi*Y_W  +: Y_W];
        assign in_w[gi] = spr_w[gi*WH_W +: WH_W];
        assign in_h[gi] = spr_h[gi*WH_W +: WH_W];
        assign in_c[gi] = spr_c[gi*C_W  +: C_W];
    end

    // Geometry of what was last drawn per slot, used to erase it next frame
    logic [X_W-1:0]     snap_x_reg [NUM_SPR];
    logic [Y_W-1:0]     snap_y_reg [NUM_SPR];
    logic [WH_W-1:0]    snap_w_reg [NUM_SPR];
    logic [WH_W-1:0]    snap_h_reg [NUM_SPR];
    logic [NUM_SPR-1:0] snap_valid_reg;

    state_t             state_reg;
    logic [SLOT_W-1:0]  slot_reg;

    logic last_slot;
    assign last_slot = (slot_reg == LAST_SLOT);
    assign busy      = (state_reg != IDLE);

    // Sequencer: slot walk, snapshot capture and registered drawer/update outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            slot_reg       <= '0;
            snap_valid_reg <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                snap_x_reg[i] <= '0;
                snap_y_reg[i] <= '0;
                snap_w_reg[i] <= '0;
                snap_h_reg[i] <= '0;
            end
            update_en  <= 1'b0;
            rect_start <= 1'b0;
            rect_x     <= '0;
            rect_y     <= '0;
            rect_w     <= '0;
            rect_h     <= '0;
            rect_c     <= '0;
            overrun    <= 1'b0;
        end else begin
            rect_start <= 1'b0;
            update_en  <= 1'b0;

            // A tick while a frame is still in progress is dropped but remembered
            if (tick && state_reg != IDLE) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        slot_reg  <= '0;
                        state_reg <= ERASE_SEL;
                    end
                end

                ERASE_SEL: begin
                    if (snap_valid_reg[slot_reg]) begin
                        rect_x     <= snap_x_reg[slot_reg];
                        rect_y     <= snap_y_reg[slot_reg];
                        rect_w     <= snap_w_reg[slot_reg];
                        rect_h     <= snap_h_reg[slot_reg];
                        rect_c     <= BG_COLOUR;
                        rect_start <= 1'b1;
                        state_reg  <= ERASE_WAIT;
                    end else if (last_slot) begin
                        // update_en rises together with entry into UPDATE
                        update_en <= 1'b1;
                        state_reg <= UPDATE;
                    end else begin
                        slot_reg <= slot_reg + SLOT_W'(1);
                    end
                end

                ERASE_WAIT: begin
                    // A done coincident with our own start pulse is stale
                    if (rect_done && !rect_start) begin
                        if (last_slot) begin
                            update_en <= 1'b1;
                            state_reg <= UPDATE;
                        end else begin
                            slot_reg  <= slot_reg + SLOT_W'(1);
                            state_reg <= ERASE_SEL;
                        end
                    end
                end

                UPDATE: begin
                    state_reg <= SETTLE;
                end

                SETTLE: begin
                    slot_reg  <= '0;
                    state_reg <= DRAW_SEL;
                end

                DRAW_SEL: begin
                    if (spr_valid[slot_reg]) begin
                        snap_x_reg[slot_reg]     <= in_x[slot_reg];
                        snap_y_reg[slot_reg]     <= in_y[slot_reg];
                        snap_w_reg[slot_reg]     <= in_w[slot_reg];
                        snap_h_reg[slot_reg]     <= in_h[slot_reg];
                        snap_valid_reg[slot_reg] <= 1'b1;
                        rect_x     <= in_x[slot_reg];
                        rect_y     <= in_y[slot_reg];
                        rect_w     <= in_w[slot_reg];
                        rect_h     <= in_h[slot_reg];
                        rect_c     <= in_c[slot_reg];
                        rect_start <= 1'b1;
                        state_reg  <= DRAW_WAIT;
                    end else begin
                        snap_valid_reg[slot_reg] <= 1'b0;
                        if (last_slot) begin
                            state_reg <= IDLE;
                        end else begin
                            slot_reg <= slot_reg + SLOT_W'(1);
                        end
                    end
                end

                DRAW_WAIT: begin
                    if (rect_done && !rect_start) begin
                        if (last_slot) begin
                            state_reg <= IDLE;
                        end else begin
                            slot_reg  <= slot_reg + SLOT_W'(1);
                            state_reg <= DRAW_SEL;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: expected rectangles and update
// pulses are queued when a frame's inputs are set and compared as they appear.
module tb_sprite_draw_scheduler;

    logic        clk;
    logic        resetn;
    logic [39:0] spr_x;
    logic [34:0] spr_y;
    logic [24:0] spr_w;
    logic [24:0] spr_h;
    logic [14:0] spr_c;
    logic [4:0]  spr_valid;
    logic        update_en;
    logic        rect_start;
    logic [7:0]  rect_x;
    logic [6:0]  rect_y;
    logic [4:0]  rect_w;
    logic [4:0]  rect_h;
    logic [2:0]  rect_c;
    logic        rect_done;
    logic        busy;
    logic        overrun;

    sprite_draw_scheduler #(
        .NUM_SPR   (5),
        .FRAME_DIV (200),
        .BG_COLOUR (3'b000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_w      (spr_w),
        .spr_h      (spr_h),
        .spr_c      (spr_c),
        .spr_valid  (spr_valid),
        .update_en  (update_en),
        .rect_start (rect_start),
        .rect_x     (rect_x),
        .rect_y     (rect_y),
        .rect_w     (rect_w),
        .rect_h     (rect_h),
        .rect_c     (rect_c),
        .rect_done  (rect_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game-state inputs
    logic [7:0] bx [5];
    logic [6:0] by [5];
    logic [4:0] bw [5];
    logic [4:0] bh [5];
    logic [2:0] bc [5];
    logic [4:0] bv;

    for (genvar gi = 0; gi < 5; gi++) begin : g_pack
        assign spr_x[gi*8 +: 8] = bx[gi];
        assign spr_y[gi*7 +: 7] = by[gi];
        assign spr_w[gi*5 +: 5] = bw[gi];
        assign spr_h[gi*5 +: 5] = bh[gi];
        assign spr_c[gi*3 +: 3] = bc[gi];
    end
    assign spr_valid = bv;

    typedef struct packed {
        logic        upd;
        logic [27:0] r;
    } exp_t;

    exp_t        exp_q [$];
    logic        mv [5];
    logic [27:0] mr [5];

    int total = 0;
    int bad   = 0;
    int ack_delay;
    int start_lat_exp;
    int upd_lat_exp;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Queue what one frame must produce and advance the reference snapshot
    task automatic push_frame();
        logic [27:0] r;
        for (int i = 0; i < 5; i++) begin
            if (mv[i]) exp_q.push_back({1'b0, mr[i][27:3], 3'b000});
        end
        exp_q.push_back({1'b1, 28'd0});
        for (int i = 0; i < 5; i++) begin
            if (bv[i]) begin
                r = {bx[i], by[i], bw[i], bh[i], bc[i]};
                exp_q.push_back({1'b0, r});
                mv[i] = 1'b1;
                mr[i] = r;
            end else begin
                mv[i] = 1'b0;
            end
        end
    endtask

    task automatic run_frame();
        int n;
        n = 0;
        while (!busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("frame_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_val("frame_end", {31'd0, busy}, 32'd0);
        check_val("q_empty", exp_q.size(), 32'd0);
    endtask

    // Drawer model: acknowledge each start after ack_delay cycles
    initial begin
        rect_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && rect_start) begin
                for (int k = 0; k < ack_delay; k++) begin
                    @(posedge clk);
                    if (!resetn) break;
                end
                if (resetn) begin
                    #1 rect_done = 1'b1;
                    @(posedge clk);
                    #1 rect_done = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every start/update against the scoreboard
    int          cyc = 0;
    int          busy_rise = 0;
    logic        busy_prev = 1'b0;
    logic        first_start = 1'b0;
    logic [27:0] held = '0;
    always @(negedge clk) begin
        exp_t        e;
        logic [27:0] cur;
        cur = {rect_x, rect_y, rect_w, rect_h, rect_c};
        if (!resetn) begin
            busy_prev = 1'b0;
        end else begin
            cyc++;
            if (busy && !busy_prev) begin
                busy_rise   = cyc;
                first_start = 1'b1;
            end
            busy_prev = busy;
            if (rect_start) begin
                held = cur;
                $display("cyc %0d rect x=%0d y=%0d w=%0d h=%0d c=%0d",
                         cyc, rect_x, rect_y, rect_w, rect_h, rect_c);
                if (first_start && start_lat_exp >= 0)
                    check_val("start_lat", cyc - busy_rise, start_lat_exp);
                first_start = 1'b0;
                check_val("q_avail", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("rect_kind", {31'd0, e.upd}, 32'd0);
                    check_val("rect", {4'd0, cur}, {4'd0, e.r});
                end
            end
            if (update_en) begin
                $display("cyc %0d update_en", cyc);
                if (upd_lat_exp >= 0)
                    check_val("upd_lat", cyc - busy_rise, upd_lat_exp);
                check_val("q_avail", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("upd_kind", {31'd0, e.upd}, 32'd1);
                end
            end
            if (rect_done) begin
                check_val("hold", {4'd0, cur}, {4'd0, held});
            end
        end
    end

    initial begin
        int n;
        resetn        = 1'b0;
        ack_delay     = 5;
        start_lat_exp = -1;
        upd_lat_exp   = -1;
        bv            = '0;
        for (int i = 0; i < 5; i++) begin
            bx[i] = '0; by[i] = '0; bw[i] = '0; bh[i] = '0; bc[i] = '0;
            mv[i] = 1'b0; mr[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_start", {31'd0, rect_start}, 32'd0);
        check_val("rst_upd", {31'd0, update_en}, 32'd0);
        check_val("rst_ovr", {31'd0, overrun}, 32'd0);
        check_val("rst_rect", {24'd0, rect_x}, 32'd0);

        // Frame 1: nothing to erase, tick to update_en = 6 (busy rise + 5)
        bx[0] = 8'd10; by[0] = 7'd20; bw[0] = 5'd10; bh[0] = 5'd10; bc[0] = 3'b101;
        bv = 5'b00001;
        push_frame();
        upd_lat_exp = 5;
        resetn = 1'b1;
        run_frame();
        upd_lat_exp = -1;

        // Frame 2: slot 0 moved; erase old then draw new, start 2 cycles after tick
        bx[0] = 8'd12;
        push_frame();
        start_lat_exp = 1;
        run_frame();
        start_lat_exp = -1;

        // Frame 3: all slots valid with distinct geometry
        for (int i = 0; i < 5; i++) begin
            bx[i] = 8'(30 + 20*i); by[i] = 7'(5 + 10*i);
            bw[i] = 5'(3 + i);     bh[i] = 5'(4 + i); bc[i] = 3'(i + 1);
        end
        bv = 5'b11111;
        push_frame();
        run_frame();

        // Frame 4: slot 2 goes invalid -> erased once, not redrawn
        bv = 5'b11011;
        push_frame();
        run_frame();

        // Frame 5: slot 2 no longer erased
        push_frame();
        run_frame();

        // Slow drawer: ticks arrive while busy
        check_val("ovr_before", {31'd0, overrun}, 32'd0);
        ack_delay = 300;
        bv = 5'b00001;
        push_frame();
        run_frame();
        check_val("ovr_set", {31'd0, overrun}, 32'd1);
        ack_delay = 5;
        push_frame();
        run_frame();
        check_val("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset during DRAW_WAIT
        push_frame();
        n = 0;
        while (!update_en && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("saw_upd", {31'd0, update_en}, 32'd1);
        n = 0;
        while (!rect_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("saw_draw", {31'd0, rect_start}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_start", {31'd0, rect_start}, 32'd0);
        check_val("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) mv[i] = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // First frame after reset erases nothing
        push_frame();
        upd_lat_exp = 5;
        run_frame();
        upd_lat_exp = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
